// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  // Stream source / RAM observer side.
  modport master (
    output s_valid, s_data,
    input  s_ready, we, waddr, wdata
  );

  // Loader side: consumes the stream, drives the write port.
  modport slave (
    input  s_valid, s_data,
    output s_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte image (16-bit word count,
// big-endian words, XOR checksum), writes words into the instruction RAM and
// releases core_rst only once the checksum has been verified.
module imem_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  output logic          core_rst,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} state_t;

  // Largest word count that fits between BASE_ADDR and the top of the RAM.
  localparam logic [31:0] CAP = 32'((64'd1 << ADDR_W) - 64'(BASE_ADDR));

  state_t      state, state_nx;
  logic [7:0]  cnt_hi;
  logic [15:0] cnt;
  logic [15:0] idx;
  logic [1:0]  bcnt;
  logic [23:0] wbuf;
  logic [7:0]  csum;

  logic        xfer;
  logic [31:0] n_hdr;
  logic        last_byte;
  logic        ready_nx, done_nx, err_nx, core_rst_nx, we_nx;

  assign xfer      = bus.s_valid & bus.s_ready;
  assign n_hdr     = {16'h0, cnt_hi, bus.s_data};
  assign last_byte = (bcnt == 2'd3);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; stalls (no transfer) hold the current state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = HDR_HI;
      HDR_HI: if (xfer) state_nx = HDR_LO;
      HDR_LO: if (xfer) begin
        if (n_hdr > CAP)       state_nx = ERR;
        else if (n_hdr == '0)  state_nx = CSUM;
        else                   state_nx = DATA;
      end
      DATA:   if (xfer && last_byte && (idx + 16'd1 == cnt)) state_nx = CSUM;
      CSUM:   if (xfer) state_nx = (bus.s_data == csum) ? DONE : ERR;
      DONE:   state_nx = DONE;
      ERR:    state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from the next state, so every output leaves a flop.
  always_comb begin
    ready_nx    = (state_nx == HDR_HI) || (state_nx == HDR_LO) ||
                  (state_nx == DATA)   || (state_nx == CSUM);
    done_nx     = (state_nx == DONE);
    err_nx      = (state_nx == ERR);
    core_rst_nx = (state_nx != DONE);
    we_nx       = (state == DATA) && xfer && last_byte;
  end

  // Registered outputs and framing datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.s_ready <= 1'b0;
      bus.we      <= 1'b0;
      bus.waddr   <= ADDR_W'(BASE_ADDR);
      bus.wdata   <= '0;
      core_rst    <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      cnt_hi      <= '0;
      cnt         <= '0;
      idx         <= '0;
      bcnt        <= '0;
      wbuf        <= '0;
      csum        <= '0;
    end else begin
      bus.s_ready <= ready_nx;
      bus.we      <= we_nx;
      core_rst    <= core_rst_nx;
      done        <= done_nx;
      err         <= err_nx;
      if (xfer && (state == HDR_HI || state == HDR_LO || state == DATA))
        csum <= csum ^ bus.s_data;
      if (xfer && state == HDR_HI) cnt_hi <= bus.s_data;
      if (xfer && state == HDR_LO) cnt    <= {cnt_hi, bus.s_data};
      if (xfer && state == DATA) begin
        wbuf <= {wbuf[15:0], bus.s_data};
        bcnt <= bcnt + 2'd1;
      end
      // Header overflow check guarantees idx stays inside the RAM.
      if (we_nx) begin
        bus.waddr <= ADDR_W'(BASE_ADDR) + idx[ADDR_W-1:0];
        bus.wdata <= {wbuf, bus.s_data};
        idx       <= idx + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_imem_loader;

  typedef logic [7:0]  bq_t [$];
  typedef logic [43:0] wq_t [$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(12)) bus ();
  imem_loader_if #(.ADDR_W(4))  bus4 ();
  logic core_rst, done, err;
  logic core_rst4, done4, err4;

  imem_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .core_rst(core_rst), .done(done), .err(err));

  imem_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave),
    .core_rst(core_rst4), .done(done4), .err(err4));

  int nvec = 0;
  int nerr = 0;

  // Monitors: write log, write timing and back-to-back strobe detection.
  int  cyc_cnt = 0;
  wq_t wq, wq4;
  int  we_cyc[$];
  int  acc_cyc[$];
  int  dbl = 0, dbl4 = 0;
  logic pwe = 1'b0, pwe4 = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (bus.we) begin
      wq.push_back({12'(bus.waddr), bus.wdata});
      we_cyc.push_back(cyc_cnt);
    end
    if (bus4.we) wq4.push_back({12'(bus4.waddr), bus4.wdata});
    if (bus.we && pwe)   dbl  <= dbl + 1;
    if (bus4.we && pwe4) dbl4 <= dbl4 + 1;
    pwe  <= bus.we;
    pwe4 <= bus4.we;
  end

  // Reference model: whole-frame interpretation from the framing rules.
  task automatic model(input bq_t b, input int aw, output wq_t w, output bit edone);
    int n;
    logic [7:0] x;
    w = {};
    edone = 1'b0;
    n = int'(b[0]) * 256 + int'(b[1]);
    if (n > (1 << aw)) return;
    for (int k = 0; k < n; k++)
      w.push_back({12'(k), b[2+4*k], b[3+4*k], b[4+4*k], b[5+4*k]});
    x = 8'h00;
    for (int j = 0; j < b.size() - 1; j++) x = x ^ b[j];
    edone = (b[b.size()-1] == x);
  endtask

  task automatic mkframe(input int n, input bit bad, output bq_t b);
    logic [7:0] x;
    b = {};
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    for (int k = 0; k < 4 * n; k++) b.push_back(8'($urandom));
    x = 8'h00;
    foreach (b[j]) x = x ^ b[j];
    b.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  // Byte driver. mode 0: back-to-back; 1: toggling valid with 3-cycle gaps;
  // 2: random gaps. Returns at the negedge following the last transfer.
  task automatic send(input bq_t b, input int sel, input int mode);
    int  i = 0;
    int  cyc = 0;
    bit  v;
    logic rdy;
    while (i < b.size()) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0) && (cyc % 10 < 7);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      rdy = sel ? bus4.s_ready : bus.s_ready;
      if (sel) begin bus4.s_valid = v; bus4.s_data = v ? b[i] : 8'($urandom); end
      else     begin bus.s_valid  = v; bus.s_data  = v ? b[i] : 8'($urandom); end
      if (v && rdy) begin
        acc_cyc.push_back(cyc_cnt + 1);
        i++;
      end
      cyc++;
      if (cyc > 3000) begin
        $display("FAIL send_timeout: accepted %0d of %0d bytes", i, b.size());
        nvec++; nerr++;
        break;
      end
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus4.s_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    wq = {}; wq4 = {}; we_cyc = {}; acc_cyc = {};
    dbl = 0; dbl4 = 0;
    rst = 1'b0;
  endtask

  bq_t f1;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nvec++;
    if ({bus.s_ready, bus.we, bus.waddr, bus.wdata, core_rst, done, err} !==
        {1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_state: rdy=%b we=%b waddr=%h wdata=%h core_rst=%b done=%b err=%b want 0 0 000 0 1 0 0",
               bus.s_ready, bus.we, bus.waddr, bus.wdata, core_rst, done, err);
    end
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (bus.s_ready !== 1'b1) begin
      nerr++; $display("FAIL ready_after_idle: got %b want 1", bus.s_ready);
    end
  endtask

  task automatic test_load_n2();
    do_reset();
    send(f1, 0, 0);
    repeat (2) @(negedge clk);
    nvec++;
    if (wq.size() != 2 || wq[0] !== {12'h000, 32'h20080005} || wq[1] !== {12'h001, 32'h01095020}) begin
      nerr++; $display("FAIL load_n2_writes: got %0d writes want 2 (000:20080005, 001:01095020)", wq.size());
    end
    nvec++;
    if (we_cyc.size() != 2 || acc_cyc.size() != 11 || we_cyc[0] != acc_cyc[5] || we_cyc[1] != acc_cyc[9]) begin
      nerr++; $display("FAIL load_n2_latency: we not one cycle after 4th byte");
    end
    nvec++;
    if ({done, err, core_rst, bus.s_ready} !== 4'b1000) begin
      nerr++; $display("FAIL load_n2_status: done/err/core_rst/rdy=%b want 1000", {done, err, core_rst, bus.s_ready});
    end
    // Bytes offered after completion must be ignored.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); bus.s_valid = 1'b1; bus.s_data = 8'($urandom);
    end
    @(negedge clk); bus.s_valid = 1'b0;
    nvec++;
    if (wq.size() != 2 || {done, err, core_rst} !== 3'b100) begin
      nerr++; $display("FAIL after_done_ignore: writes=%0d status=%b want 2 100", wq.size(), {done, err, core_rst});
    end
  endtask

  task automatic test_bad_csum();
    bq_t b;
    b = f1;
    b[10] = 8'h56;
    do_reset();
    send(b, 0, 0);
    repeat (2) @(negedge clk);
    nvec++;
    if (wq.size() != 2 || wq[1] !== {12'h001, 32'h01095020}) begin
      nerr++; $display("FAIL bad_csum_writes: got %0d writes want 2", wq.size());
    end
    nvec++;
    if ({done, err, core_rst, bus.s_ready} !== 4'b0110) begin
      nerr++; $display("FAIL bad_csum_status: done/err/core_rst/rdy=%b want 0110", {done, err, core_rst, bus.s_ready});
    end
  endtask

  task automatic test_empty();
    bq_t b;
    b = '{8'h00, 8'h00, 8'h00};
    do_reset();
    send(b, 0, 0);
    nvec++;
    if (wq.size() != 0 || {done, err, core_rst} !== 3'b100) begin
      nerr++; $display("FAIL empty_image: writes=%0d status=%b want 0 100", wq.size(), {done, err, core_rst});
    end
  endtask

  task automatic test_stall();
    do_reset();
    send(f1, 0, 1);
    repeat (2) @(negedge clk);
    nvec++;
    if (wq.size() != 2 || wq[0] !== {12'h000, 32'h20080005} || wq[1] !== {12'h001, 32'h01095020} || dbl != 0) begin
      nerr++; $display("FAIL stall_writes: got %0d writes (dbl=%0d) want 2", wq.size(), dbl);
    end
    nvec++;
    if ({done, err, core_rst} !== 3'b100) begin
      nerr++; $display("FAIL stall_status: %b want 100", {done, err, core_rst});
    end
  endtask

  task automatic test_overflow();
    bq_t b;
    wq_t w;
    bit  ed;
    b = '{8'h00, 8'h11};
    do_reset();
    send(b, 1, 0);
    nvec++;
    if ({err4, done4, bus4.s_ready, core_rst4} !== 4'b1001 || wq4.size() != 0) begin
      nerr++; $display("FAIL overflow_n17: err/done/rdy/core_rst=%b writes=%0d want 1001 0",
                       {err4, done4, bus4.s_ready, core_rst4}, wq4.size());
    end
    // Exactly filling the 16-word RAM is legal.
    mkframe(16, 1'b0, b);
    model(b, 4, w, ed);
    do_reset();
    send(b, 1, 2);
    repeat (2) @(negedge clk);
    nvec++;
    if (wq4 != w || {done4, err4} !== {ed, !ed} || dbl4 != 0) begin
      nerr++; $display("FAIL boundary_n16: writes=%0d want %0d done=%b err=%b", wq4.size(), w.size(), done4, err4);
    end
  endtask

  task automatic test_reset_mid();
    bq_t b;
    b = f1[0:4];
    do_reset();
    send(b, 0, 0);
    rst = 1'b1;
    #1;
    nvec++;
    if ({bus.s_ready, bus.we, bus.waddr, core_rst, done, err} !== {1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0} ||
        wq.size() != 0) begin
      nerr++; $display("FAIL reset_mid_state: rdy=%b we=%b waddr=%h status=%b writes=%0d want 0 0 000 100 0",
                       bus.s_ready, bus.we, bus.waddr, {core_rst, done, err}, wq.size());
    end
    do_reset();
    send(f1, 0, 0);
    repeat (2) @(negedge clk);
    nvec++;
    if (wq.size() != 2 || wq[0] !== {12'h000, 32'h20080005} || wq[1] !== {12'h001, 32'h01095020} ||
        {done, err, core_rst} !== 3'b100) begin
      nerr++; $display("FAIL reset_mid_resend: writes=%0d status=%b want 2 100", wq.size(), {done, err, core_rst});
    end
  endtask

  task automatic test_random();
    bq_t b;
    wq_t w;
    bit  ed;
    for (int t = 0; t < 10; t++) begin
      mkframe($urandom_range(0, 12), ($urandom_range(0, 2) == 0), b);
      model(b, 12, w, ed);
      do_reset();
      send(b, 0, $urandom_range(0, 2));
      repeat (2) @(negedge clk);
      nvec++;
      if (wq != w || dbl != 0) begin
        nerr++; $display("FAIL random_writes[%0d]: got %0d writes want %0d dbl=%0d", t, wq.size(), w.size(), dbl);
      end
      nvec++;
      if ({done, err, core_rst, bus.s_ready} !== {ed, !ed, !ed, 1'b0}) begin
        nerr++; $display("FAIL random_status[%0d]: done/err/core_rst/rdy=%b want %b",
                         t, {done, err, core_rst, bus.s_ready}, {ed, !ed, !ed, 1'b0});
      end
    end
    // Random oversized headers on the small RAM.
    for (int t = 0; t < 3; t++) begin
      int n;
      n = $urandom_range(17, 600);
      b = '{8'(n >> 8), 8'(n)};
      do_reset();
      send(b, 1, 2);
      nvec++;
      if ({err4, done4, bus4.s_ready} !== 3'b100 || wq4.size() != 0) begin
        nerr++; $display("FAIL random_overflow[%0d] n=%0d: err/done/rdy=%b want 100", t, n, {err4, done4, bus4.s_ready});
      end
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;  bus.s_data = 8'h00;
    bus4.s_valid = 1'b0; bus4.s_data = 8'h00;
    f1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
    test_reset();
    test_load_n2();
    test_bad_csum();
    test_empty();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
